// File: rtl/fft_stage_sequencer_pkg.sv
// Shared widths and sequencer state encoding for the in-place FFT datapath.
// The address unit uses the same width helpers so both sides agree on bus sizes.
package fft_pkg;

  localparam int FFT_N_DEFAULT = 1024;

  function automatic int log2n(input int n);
    return $clog2(n);
  endfunction

  function automatic int log2n2(input int n);
    return $clog2(n) - 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/fft_stage_sequencer_addr_delay_line.sv
// Freezable shift register carrying {valid, addr1, addr2} from read capture to write-back.
// pending reports entries that have not yet reached the output stage.
module addr_delay_line #(
  parameter int DEPTH = 3,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  input  logic [W-1:0] in_addr1,
  input  logic [W-1:0] in_addr2,
  output logic         out_valid,
  output logic [W-1:0] out_addr1,
  output logic [W-1:0] out_addr2,
  output logic         pending
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [W-1:0]     a1_q [DEPTH];
  logic [W-1:0]     a2_q [DEPTH];
  logic [W-1:0]     a1_d [DEPTH];
  logic [W-1:0]     a2_d [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign v_d[gi]  = in_valid;
        assign a1_d[gi] = in_addr1;
        assign a2_d[gi] = in_addr2;
      end else begin : g_tail
        assign v_d[gi]  = v_q[gi-1];
        assign a1_d[gi] = a1_q[gi-1];
        assign a2_d[gi] = a2_q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a1_q[i] <= '0;
        a2_q[i] <= '0;
      end
    end else if (en) begin
      v_q <= v_d;
      for (int i = 0; i < DEPTH; i++) begin
        a1_q[i] <= a1_d[i];
        a2_q[i] <= a2_d[i];
      end
    end
  end

  // The output stage is excluded: its entry retires in the current cycle.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      pending = pending | v_q[i];
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_addr1 = a1_q[DEPTH-1];
  assign out_addr2 = a2_q[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage/pair issue sequencer for an in-place radix-2 FFT, with write-back address
// delay matched to the butterfly pipeline and a drain between stages.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter  int N          = FFT_N_DEFAULT,
  parameter  int BF_LATENCY = 4,
  localparam int LOG2N      = log2n(N),
  localparam int PAIR_W     = log2n2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic [LOG2N-1:0]  stage,
  output logic [PAIR_W-1:0] pair_id,
  output logic              rd_en,
  input  logic [LOG2N-1:0]  agu_addr1,
  input  logic [LOG2N-1:0]  agu_addr2,
  output logic              wr_en,
  output logic [LOG2N-1:0]  wr_addr1,
  output logic [LOG2N-1:0]  wr_addr2,
  output logic              busy,
  output logic              done
);

  localparam logic [LOG2N-1:0]  STAGE_LAST = LOG2N'(LOG2N - 1);
  localparam logic [PAIR_W-1:0] PAIR_LAST  = '1;

  seq_state_e        state_q, state_d;
  logic [LOG2N-1:0]  stage_q, stage_d;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic              rd_q;
  logic [LOG2N-1:0]  wr_addr1_q, wr_addr2_q;
  logic              dl_valid, dl_pending;
  logic [LOG2N-1:0]  dl_addr1, dl_addr2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      stage_q    <= '0;
      pair_q     <= '0;
      rd_q       <= 1'b0;
      wr_addr1_q <= '0;
      wr_addr2_q <= '0;
    end else begin
      state_q    <= state_d;
      stage_q    <= stage_d;
      pair_q     <= pair_d;
      wr_addr1_q <= wr_addr1;
      wr_addr2_q <= wr_addr2;
      if (!hold) rd_q <= rd_en;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    pair_d  = pair_q;
    rd_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          stage_d = '0;
          pair_d  = '0;
        end
      end
      ST_ISSUE: begin
        if (!hold) begin
          rd_en = 1'b1;
          if (pair_q == PAIR_LAST) state_d = ST_DRAIN;
          else                     pair_d  = pair_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Leave on the cycle of the stage's final write so the next read follows it directly.
        if (!hold && !rd_q && !dl_pending) begin
          if (stage_q == STAGE_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            stage_d = stage_q + 1'b1;
            pair_d  = '0;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  addr_delay_line #(
    .DEPTH (BF_LATENCY - 1),
    .W     (LOG2N)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .en        (!hold),
    .in_valid  (rd_q),
    .in_addr1  (agu_addr1),
    .in_addr2  (agu_addr2),
    .out_valid (dl_valid),
    .out_addr1 (dl_addr1),
    .out_addr2 (dl_addr2),
    .pending   (dl_pending)
  );

  assign wr_en    = dl_valid && !hold;
  assign wr_addr1 = wr_en ? dl_addr1 : wr_addr1_q;
  assign wr_addr2 = wr_en ? dl_addr2 : wr_addr2_q;
  assign stage    = stage_q;
  assign pair_id  = pair_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer at N=8, BF_LATENCY=4 with a registered
// address-unit model; expected schedules derive from the unheld-cycle timeline.
module tb_fft_stage_sequencer;

  localparam int N      = 8;
  localparam int BF     = 4;
  localparam int LOG2N  = 3;
  localparam int PW     = 2;
  localparam int P      = N / 2 + BF;
  localparam int DONE_U = 1 + LOG2N * P;

  logic             clk = 1'b0;
  logic             rst, start, hold;
  logic [LOG2N-1:0] stage;
  logic [PW-1:0]    pair_id;
  logic             rd_en, wr_en, busy, done;
  logic [LOG2N-1:0] agu_addr1, agu_addr2, wr_addr1, wr_addr2;

  int checks = 0;
  int errors = 0;
  logic [2*LOG2N-1:0] exp_q[$];
  logic [LOG2N-1:0]   last_a1, last_a2;

  fft_stage_sequencer #(.N(N), .BF_LATENCY(BF)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .hold      (hold),
    .stage     (stage),
    .pair_id   (pair_id),
    .rd_en     (rd_en),
    .agu_addr1 (agu_addr1),
    .agu_addr2 (agu_addr2),
    .wr_en     (wr_en),
    .wr_addr1  (wr_addr1),
    .wr_addr2  (wr_addr2),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [2*LOG2N-1:0] agu_f(input int s, input int p);
    int half, a1, a2;
    half = (N / 2) >> s;
    a1   = (p / half) * 2 * half + (p % half);
    a2   = a1 + half;
    return {a1[LOG2N-1:0], a2[LOG2N-1:0]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) {agu_addr1, agu_addr2} <= '0;
    else if (rd_en) {agu_addr1, agu_addr2} <= agu_f(int'(stage), int'(pair_id));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_stage"}, 32'(stage), 0);
    check({pfx, "_pair"}, 32'(pair_id), 0);
    check({pfx, "_rd_en"}, 32'(rd_en), 0);
    check({pfx, "_wr_en"}, 32'(wr_en), 0);
    check({pfx, "_wr_addr1"}, 32'(wr_addr1), 0);
    check({pfx, "_wr_addr2"}, 32'(wr_addr2), 0);
    check({pfx, "_busy"}, 32'(busy), 0);
    check({pfx, "_done"}, 32'(done), 0);
  endtask

  task automatic run_xfer(input string name, input logic [63:0] hold_m,
                          input logic [63:0] start_m, input int rst_at);
    int u, c, s, k;
    bit rd_x, wr_x, dn_x, bz_x;
    logic [2*LOG2N-1:0] e;
    u = 0;
    c = 0;
    @(posedge clk); #1;
    start = start_m[0];
    hold  = hold_m[0];
    $display("XFER %s begin", name);
    while (u <= DONE_U + 2) begin
      if (c == rst_at) begin
        check("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; hold = 1'b0;
        exp_q.delete();
        last_a1 = '0;
        last_a2 = '0;
        $display("XFER %s reset at cycle %0d", name, c);
        return;
      end
      @(negedge clk);
      if (hold_m[c]) begin
        check("hold_rd_en", 32'(rd_en), 0);
        check("hold_wr_en", 32'(wr_en), 0);
        check("hold_done", 32'(done), 0);
        check("hold_busy", 32'(busy), 32'(u >= 1 && u <= DONE_U));
        if (u >= 1 && u < DONE_U && ((u - 1) % P) < N / 2) begin
          check("hold_pair", 32'(pair_id), 32'((u - 1) % P));
          check("hold_stage", 32'(stage), 32'((u - 1) / P));
        end
      end else begin
        s    = (u - 1) / P;
        k    = (u - 1) % P;
        rd_x = (u >= 1) && (u <= LOG2N * P) && (k < N / 2);
        wr_x = (u >= 1) && (u <= LOG2N * P) && (k >= BF);
        dn_x = (u == DONE_U);
        bz_x = (u >= 1) && (u <= DONE_U);
        check("rd_en", 32'(rd_en), 32'(rd_x));
        check("wr_en", 32'(wr_en), 32'(wr_x));
        check("done", 32'(done), 32'(dn_x));
        check("busy", 32'(busy), 32'(bz_x));
        if (rd_x) begin
          check("stage", 32'(stage), 32'(s));
          check("pair_id", 32'(pair_id), 32'(k));
          exp_q.push_back(agu_f(s, k));
        end
        u++;
      end
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 32'(wr_en), 0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr1", 32'(wr_addr1), 32'(e[2*LOG2N-1:LOG2N]));
          check("wr_addr2", 32'(wr_addr2), 32'(e[LOG2N-1:0]));
          last_a1 = e[2*LOG2N-1:LOG2N];
          last_a2 = e[LOG2N-1:0];
          $display("WR %s cycle %0d addr1 %0d addr2 %0d", name, c, wr_addr1, wr_addr2);
        end
      end else begin
        check("wr_addr1_hold", 32'(wr_addr1), 32'(last_a1));
        check("wr_addr2_hold", 32'(wr_addr2), 32'(last_a2));
      end
      @(posedge clk); #1;
      c++;
      start = start_m[c];
      hold  = hold_m[c];
    end
    check("sb_empty", 32'(exp_q.size()), 0);
    start = 1'b0;
    hold  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0;
    last_a1 = '0; last_a2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    run_xfer("nohold", 64'h0, 64'h1, -1);
    run_xfer("hold_issue", (64'd1 << 2) | (64'd1 << 3), 64'h1, -1);
    run_xfer("hold_drain", 64'd1 << 6, 64'h1, -1);
    run_xfer("reset_mid", 64'h0, 64'h1, 11);
    run_xfer("after_reset", 64'h0, 64'h1, -1);
    run_xfer("start_ignored", 64'h0,
             64'h1 | (64'd1 << 3) | (64'd1 << 10) | (64'd1 << 25), -1);
    run_xfer("restart", 64'h0, 64'h1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
